// File: rtl/core_run_ctrl.sv
// Run/halt/single-step controller for a soft core: synchronized, debounced board inputs drive a Moore FSM.
// Optional macro CORE_RUN_CTRL_CYCLE_CNT_EN enables the saturating enabled-cycle counter on cycle_cnt_o.

module core_run_ctrl_deb #(
  parameter int DEB_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_lvl
);
  logic [1:0]  r_sync;
  logic [15:0] r_cnt;
  logic        r_lvl;

  localparam logic [15:0] CNT_LAST = 16'(DEB_CYCLES - 1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_lvl  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      // Any sample agreeing with the current level restarts the stability window.
      if (r_sync[1] != r_lvl) begin
        if (r_cnt == CNT_LAST) begin
          r_lvl <= r_sync[1];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_lvl = r_lvl;
endmodule

module core_run_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int RST_HOLD   = 4
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic        step_btn_i,
  input  logic        run_sw_i,
  input  logic        halt_req_i,
  output logic        core_en_o,
  output logic        core_rst_o,
  output logic [1:0]  state_o,
  output logic        rearm_o,
  output logic [15:0] cycle_cnt_o
);
  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_HALT = 2'd1,
    S_STEP = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);

  logic [1:0]  w_raw;
  logic [1:0]  w_deb;
  logic        w_step_deb;
  logic        w_run_deb;
  logic        w_step_evt;

  state_t      r_state;
  logic [15:0] r_hold;
  logic        r_rearm;
  logic        r_core_en;
  logic        r_core_rst;
  logic        r_step_prev;

  assign w_raw = {run_sw_i, step_btn_i};

  core_run_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb [1:0] (
    .i_clk   (clk_i),
    .i_rst_n (reset_n),
    .i_raw   (w_raw),
    .o_lvl   (w_deb)
  );

  assign w_step_deb = w_deb[0];
  assign w_run_deb  = w_deb[1];
  assign w_step_evt = w_step_deb & ~r_step_prev;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_RST;
      r_hold      <= '0;
      r_rearm     <= 1'b0;
      r_core_en   <= 1'b0;
      r_core_rst  <= 1'b1;
      r_step_prev <= 1'b0;
    end else begin
      r_step_prev <= w_step_deb;
      if (!w_run_deb) r_rearm <= 1'b0;
      case (r_state)
        S_RST: begin
          // Step events seen here are dropped: the pulse is gone by the time HALT is reached.
          if (r_hold == HOLD_LAST) begin
            r_state    <= S_HALT;
            r_core_rst <= 1'b0;
          end else begin
            r_hold <= r_hold + 16'd1;
          end
        end
        S_HALT: begin
          if (w_run_deb && !r_rearm && !halt_req_i) begin
            r_state   <= S_RUN;
            r_core_en <= 1'b1;
          end else if (w_step_evt) begin
            r_state   <= S_STEP;
            r_core_en <= 1'b1;
          end
        end
        S_STEP: begin
          r_state   <= S_HALT;
          r_core_en <= 1'b0;
        end
        S_RUN: begin
          if (halt_req_i) begin
            r_state   <= S_HALT;
            r_core_en <= 1'b0;
            r_rearm   <= 1'b1;
          end else if (!w_run_deb) begin
            r_state   <= S_HALT;
            r_core_en <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_RST;
          r_core_en <= 1'b0;
        end
      endcase
    end
  end

  assign core_en_o  = r_core_en;
  assign core_rst_o = r_core_rst;
  assign state_o    = r_state;
  assign rearm_o    = r_rearm;

`ifdef CORE_RUN_CTRL_CYCLE_CNT_EN
  logic [15:0] r_cycle_cnt;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_cycle_cnt <= '0;
    end else if (r_state == S_RST) begin
      r_cycle_cnt <= '0;
    end else if (r_core_en && (r_cycle_cnt != 16'hFFFF)) begin
      r_cycle_cnt <= r_cycle_cnt + 16'd1;
    end
  end

  assign cycle_cnt_o = r_cycle_cnt;
`else
  assign cycle_cnt_o = 16'h0000;
`endif
endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl (DEB_CYCLES=4, RST_HOLD=4) with a cycle-level reference model.
module tb_core_run_ctrl;
  localparam int DEB = 4;
  localparam int HOLD = 4;
`ifdef CORE_RUN_CTRL_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        step_btn = 1'b0;
  logic        run_sw = 1'b0;
  logic        halt_req = 1'b0;
  logic        core_en;
  logic        core_rst;
  logic [1:0]  state;
  logic        rearm;
  logic [15:0] cycle_cnt;

  int checks = 0;
  int fails = 0;
  int en_cycles = 0;
  bit chk_en = 1'b0;

  core_run_ctrl #(.DEB_CYCLES(DEB), .RST_HOLD(HOLD)) dut (
    .clk_i       (clk),
    .reset_n     (reset_n),
    .step_btn_i  (step_btn),
    .run_sw_i    (run_sw),
    .halt_req_i  (halt_req),
    .core_en_o   (core_en),
    .core_rst_o  (core_rst),
    .state_o     (state),
    .rearm_o     (rearm),
    .cycle_cnt_o (cycle_cnt)
  );

  initial forever #5 clk = ~clk;

  // Reference model: raw inputs delayed two samples, counted stability windows,
  // and the run/halt/step rules applied to the pre-edge values.
  bit [1:0] m_step_pipe, m_run_pipe;
  bit       m_step_lvl, m_run_lvl, m_step_seen, m_rearm;
  int       m_step_win, m_run_win, m_since_rst, m_state, m_en_cnt;

  task automatic deb_upd(input bit s, input bit lvl_i, input int win_i,
                         output bit lvl_o, output int win_o);
    lvl_o = lvl_i;
    win_o = 0;
    if (s != lvl_i) begin
      win_o = win_i + 1;
      if (win_o == DEB) begin
        lvl_o = s;
        win_o = 0;
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_step_pipe = '0; m_run_pipe = '0;
      m_step_lvl = 0; m_run_lvl = 0; m_step_seen = 0; m_rearm = 0;
      m_step_win = 0; m_run_win = 0; m_since_rst = 0; m_state = 0; m_en_cnt = 0;
    end else begin
      bit evt;
      int nxt;
      evt = m_step_lvl && !m_step_seen;
      nxt = m_state;
      if (m_state == 0) m_en_cnt = 0;
      else if (m_state >= 2 && m_en_cnt < 65535) m_en_cnt = m_en_cnt + 1;
      case (m_state)
        0: begin m_since_rst = m_since_rst + 1; if (m_since_rst == HOLD) nxt = 1; end
        1: if (m_run_lvl && !m_rearm && !halt_req) nxt = 3; else if (evt) nxt = 2;
        2: nxt = 1;
        default: if (halt_req || !m_run_lvl) nxt = 1;
      endcase
      if (m_state == 3 && halt_req) m_rearm = 1;
      else if (!m_run_lvl) m_rearm = 0;
      m_step_seen = m_step_lvl;
      deb_upd(m_step_pipe[1], m_step_lvl, m_step_win, m_step_lvl, m_step_win);
      deb_upd(m_run_pipe[1], m_run_lvl, m_run_win, m_run_lvl, m_run_win);
      m_step_pipe = {m_step_pipe[0], step_btn};
      m_run_pipe = {m_run_pipe[0], run_sw};
      m_state = nxt;
    end
  end

  // Single compare process: all outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [20:0] got, exp;
      got = {state, core_en, core_rst, rearm, cycle_cnt};
      exp = {2'(m_state), m_state >= 2, m_state == 0, m_rearm,
             CNT_EN ? 16'(m_en_cnt) : 16'h0000};
      checks = checks + 1;
      if (got !== exp) begin
        fails = fails + 1;
        $display("FAIL model t=%0t got st=%0d en=%b rst=%b rearm=%b cnt=%0d exp st=%0d en=%b rst=%b rearm=%b cnt=%0d",
                 $time, got[20:19], got[18], got[17], got[16], got[15:0],
                 exp[20:19], exp[18], exp[17], exp[16], exp[15:0]);
      end
      if (core_en) en_cycles = en_cycles + 1;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      fails = fails + 1;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit [19:0] pat;
    pat = 20'b1111_1111_1110_1101_1011; // bit i drives cycle i; zeros at 2,5,8 are bounces
    chk_en = 1'b1;
    cyc(2);
    chk("reset_state", state, 0);
    chk("reset_core_rst", core_rst, 1);
    chk("reset_cnt", cycle_cnt, 0);
    reset_n = 1'b1;
    cyc(3);
    chk("rst_hold_3", core_rst, 1);
    cyc(1);
    chk("halt_after_hold", state, 1);
    chk("halt_en", core_en, 0);

    // Bouncy step press: one step only
    for (int i = 0; i < 20; i++) begin
      step_btn = pat[i];
      cyc(1);
    end
    step_btn = 1'b0;
    cyc(12);
    chk("step_pulses", en_cycles, 1);
    chk("step_cnt", cycle_cnt, CNT_EN ? 1 : 0);
    chk("step_back_halt", state, 1);

    // Run switch: 2 sync + 4 debounce + 1 FSM edge
    run_sw = 1'b1;
    cyc(6);
    chk("run_not_yet", state, 1);
    cyc(1);
    chk("run_entered", state, 3);
    cyc(100);
    chk("run_cnt_101", cycle_cnt, CNT_EN ? 101 : 0);

    // Core halt locks out RUN until the switch is cycled
    halt_req = 1'b1;
    cyc(1);
    halt_req = 1'b0;
    chk("halt_en_drop", core_en, 0);
    chk("halt_rearm", rearm, 1);
    cyc(10);
    chk("rearm_holds_halt", state, 1);
    run_sw = 1'b0;
    cyc(8);
    chk("rearm_cleared", rearm, 0);
    run_sw = 1'b1;
    cyc(7);
    chk("rerun", state, 3);

    // Simultaneous run and step: run wins
    run_sw = 1'b0;
    cyc(8);
    chk("halt_again", state, 1);
    run_sw = 1'b1;
    step_btn = 1'b1;
    cyc(7);
    chk("run_priority", state, 3);
    cyc(1);
    chk("run_priority_hold", state, 3);

    // Asynchronous reset between edges while running
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_en", core_en, 0);
    chk("async_cnt", cycle_cnt, 0);
    chk("async_rst", core_rst, 1);
    cyc(2);
    reset_n = 1'b1;
    cyc(10);
    chk("post_reset_run", state, 3);
    step_btn = 1'b0;
    run_sw = 1'b0;
    cyc(10);
    chk("final_halt", state, 1);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
